// File: rtl/regfile_port_sched.sv
// Access scheduler for a 32x32 register unit with two read ports and one write port.
// Port A carries either the rs1 read address or the write-back address, so at most one
// operation (operand read, ALU write-back or load write-back) is issued per cycle.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   rd_req_*                      operand read request from decode (valid/ready, rs1, rs2, tag)
//   rd_rsp_*                      operand response (single-cycle valid pulse, data, echoed tag)
//   wb0_* / wb1_*                 write-back requests from the ALU / load unit
//   rf_address_a/b, rf_in_a,
//   rf_wren_a                     registered drive into the register unit
//   rf_out_a/b                    registered read data from the register unit
module regfile_port_sched #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TAG_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_req_valid,
  output logic             rd_req_ready,
  input  logic [4:0]       rd_rs1,
  input  logic [4:0]       rd_rs2,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_rsp_valid,
  output logic [31:0]      rd_rsp_rs1,
  output logic [31:0]      rd_rsp_rs2,
  output logic [TAG_W-1:0] rd_rsp_tag,
  input  logic             wb0_valid,
  output logic             wb0_ready,
  input  logic [4:0]       wb0_rd,
  input  logic [31:0]      wb0_data,
  input  logic             wb1_valid,
  output logic             wb1_ready,
  input  logic [4:0]       wb1_rd,
  input  logic [31:0]      wb1_data,
  output logic [4:0]       rf_address_a,
  output logic [4:0]       rf_address_b,
  output logic [31:0]      rf_in_a,
  output logic             rf_wren_a,
  input  logic [31:0]      rf_out_a,
  input  logic [31:0]      rf_out_b
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]       starve_cnt_q, starve_cnt_d;
  logic             rr_q, rr_d;          // 0: wb0 has priority next, 1: wb1
  logic             at_limit, force_rd, any_wb;
  logic             rd_fire, wb0_fire, wb1_fire;

  // Read tag/valid follow the unit's address register and output register stages.
  logic             s1_valid_q, s2_valid_q;
  logic [TAG_W-1:0] s1_tag_q, s2_tag_q;

  always_comb begin
    at_limit = (starve_cnt_q == LIMIT);
    force_rd = rd_req_valid && at_limit;
    any_wb   = wb0_valid || wb1_valid;

    // Each ready looks only at the other requesters' valids and local state.
    rd_req_ready = at_limit || !any_wb;
    wb0_ready    = !force_rd && (!rr_q || !wb1_valid);
    wb1_ready    = !force_rd && (rr_q || !wb0_valid);

    rd_fire  = rd_req_valid && rd_req_ready;
    wb0_fire = wb0_valid && wb0_ready;
    wb1_fire = wb1_valid && wb1_ready;

    starve_cnt_d = starve_cnt_q;
    if (!rd_req_valid || rd_fire) begin
      starve_cnt_d = '0;
    end else if ((wb0_fire || wb1_fire) && !at_limit) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    rr_d = rr_q;
    if (wb0_fire) begin
      rr_d = 1'b1;
    end else if (wb1_fire) begin
      rr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
      rr_q         <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rr_q         <= rr_d;
    end
  end

  // Register-unit drive. Addresses hold when idle; writes to x0 are accepted but suppressed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_address_a <= '0;
      rf_address_b <= '0;
      rf_in_a      <= '0;
      rf_wren_a    <= 1'b0;
    end else begin
      rf_wren_a <= 1'b0;
      if (rd_fire) begin
        rf_address_a <= rd_rs1;
        rf_address_b <= rd_rs2;
      end else if (wb0_fire) begin
        rf_address_a <= wb0_rd;
        rf_in_a      <= wb0_data;
        rf_wren_a    <= |wb0_rd;
      end else if (wb1_fire) begin
        rf_address_a <= wb1_rd;
        rf_in_a      <= wb1_data;
        rf_wren_a    <= |wb1_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q   <= 1'b0;
      s1_tag_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_tag_q     <= '0;
      rd_rsp_valid <= 1'b0;
      rd_rsp_tag   <= '0;
    end else begin
      s1_valid_q   <= rd_fire;
      s1_tag_q     <= rd_fire ? rd_tag : s1_tag_q;
      s2_valid_q   <= s1_valid_q;
      s2_tag_q     <= s1_tag_q;
      rd_rsp_valid <= s2_valid_q;
      rd_rsp_tag   <= s2_tag_q;
    end
  end

  // Operand data comes straight from the unit's output registers; gating keeps it at zero
  // whenever no response is being presented (including during reset).
  assign rd_rsp_rs1 = rd_rsp_valid ? rf_out_a : '0;
  assign rd_rsp_rs2 = rd_rsp_valid ? rf_out_b : '0;

endmodule

// File: tb/tb_regfile_port_sched.sv
// Self-checking bench for regfile_port_sched: directed stimulus, scoreboard of expected
// operand responses drained by an independent monitor, plus a behavioural register unit
// (address register stage followed by output register stage).
module tb_regfile_port_sched;

  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             rd_req_valid, rd_req_ready;
  logic [4:0]       rd_rs1, rd_rs2;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_rsp_valid;
  logic [31:0]      rd_rsp_rs1, rd_rsp_rs2;
  logic [TAG_W-1:0] rd_rsp_tag;
  logic             wb0_valid, wb0_ready, wb1_valid, wb1_ready;
  logic [4:0]       wb0_rd, wb1_rd;
  logic [31:0]      wb0_data, wb1_data;
  logic [4:0]       rf_address_a, rf_address_b;
  logic [31:0]      rf_in_a;
  logic             rf_wren_a;
  logic [31:0]      rf_out_a = '0;
  logic [31:0]      rf_out_b = '0;

  always #5 clk = ~clk;

  regfile_port_sched #(
    .STARVE_LIMIT(4),
    .TAG_W       (TAG_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_rs1       (rd_rs1),
    .rd_rs2       (rd_rs2),
    .rd_tag       (rd_tag),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_rs1   (rd_rsp_rs1),
    .rd_rsp_rs2   (rd_rsp_rs2),
    .rd_rsp_tag   (rd_rsp_tag),
    .wb0_valid    (wb0_valid),
    .wb0_ready    (wb0_ready),
    .wb0_rd       (wb0_rd),
    .wb0_data     (wb0_data),
    .wb1_valid    (wb1_valid),
    .wb1_ready    (wb1_ready),
    .wb1_rd       (wb1_rd),
    .wb1_data     (wb1_data),
    .rf_address_a (rf_address_a),
    .rf_address_b (rf_address_b),
    .rf_in_a      (rf_in_a),
    .rf_wren_a    (rf_wren_a),
    .rf_out_a     (rf_out_a),
    .rf_out_b     (rf_out_b)
  );

  // Register unit model: captures addresses, then data one edge later; x0 reads as zero.
  logic [31:0] mem [32];
  logic [4:0]  ra_q = '0;
  logic [4:0]  rb_q = '0;
  initial for (int i = 0; i < 32; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (rf_wren_a && rf_address_a != 5'd0) mem[rf_address_a] <= rf_in_a;
    ra_q     <= rf_address_a;
    rb_q     <= rf_address_b;
    rf_out_a <= (ra_q == 5'd0) ? 32'd0 : mem[ra_q];
    rf_out_b <= (rb_q == 5'd0) ? 32'd0 : mem[rb_q];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0]      rs1;
    logic [31:0]      rs2;
    logic [TAG_W-1:0] tag;
    int unsigned      due;
  } exp_t;
  exp_t sb[$];

  // Monitor: every expected response must appear exactly on its due cycle, nothing else.
  always @(posedge clk) begin
    #2;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      check("rsp_missing", 32'(rd_rsp_valid), 32'd1);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      check("rsp_valid", 32'(rd_rsp_valid), 32'd1);
      check("rsp_rs1", rd_rsp_rs1, e.rs1);
      check("rsp_rs2", rd_rsp_rs2, e.rs2);
      check("rsp_tag", 32'(rd_rsp_tag), 32'(e.tag));
    end else if (rd_rsp_valid) begin
      check("rsp_unexpected", 32'(rd_rsp_valid), 32'd0);
    end
  end

  task automatic idle();
    rd_req_valid = 1'b0; rd_rs1 = '0; rd_rs2 = '0; rd_tag = '0;
    wb0_valid = 1'b0; wb0_rd = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_rd = '0; wb1_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Drives one read at the next falling edge; pushes the expectation if it is granted.
  task automatic read_cycle(input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [TAG_W-1:0] tag, input logic [31:0] e1,
                            input logic [31:0] e2);
    exp_t e;
    @(negedge clk);
    idle();
    rd_req_valid = 1'b1; rd_rs1 = rs1; rd_rs2 = rs2; rd_tag = tag;
    #1;
    check("rd_req_ready", 32'(rd_req_ready), 32'd1);
    if (rd_req_ready) begin
      e.rs1 = e1; e.rs2 = e2; e.tag = tag; e.due = cyc + 3;
      sb.push_back(e);
    end
  endtask

  initial begin
    idle();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addr_a", 32'(rf_address_a), 32'd0);
    check("rst_addr_b", 32'(rf_address_b), 32'd0);
    check("rst_in_a", rf_in_a, 32'd0);
    check("rst_wren", 32'(rf_wren_a), 32'd0);
    check("rst_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    rst = 1'b1;

    // Write x5, then read it back on the next cycle.
    @(negedge clk);
    wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'hDEADBEEF;
    #1 check("wr_wb0_ready", 32'(wb0_ready), 32'd1);
    @(negedge clk);
    check("wr_wren", 32'(rf_wren_a), 32'd1);
    check("wr_addr_a", 32'(rf_address_a), 32'd5);
    check("wr_in_a", rf_in_a, 32'hDEADBEEF);
    idle();
    rd_req_valid = 1'b1; rd_rs1 = 5'd5; rd_rs2 = 5'd0; rd_tag = 4'd3;
    #1 check("rd_req_ready", 32'(rd_req_ready), 32'd1);
    if (rd_req_ready) begin
      exp_t e;
      e.rs1 = 32'hDEADBEEF; e.rs2 = 32'd0; e.tag = 4'd3; e.due = cyc + 3;
      sb.push_back(e);
    end
    @(negedge clk);
    idle();
    check("rd_addr_a", 32'(rf_address_a), 32'd5);
    check("rd_addr_b", 32'(rf_address_b), 32'd0);
    check("rd_wren", 32'(rf_wren_a), 32'd0);
    repeat (4) @(negedge clk);

    // Fairness: both write-backs held, grants alternate starting with wb0.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("rr_wren", 32'(rf_wren_a), 32'd1);
        check("rr_addr_a", 32'(rf_address_a), (i % 2 == 1) ? 32'd1 : 32'd2);
      end
      wb0_valid = 1'b1; wb0_rd = 5'd1; wb0_data = 32'h100 + 32'(i);
      wb1_valid = 1'b1; wb1_rd = 5'd2; wb1_data = 32'h200 + 32'(i);
      #1;
      check("rr_wb0_ready", 32'(wb0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_wb1_ready", 32'(wb1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("rr_last_wren", 32'(rf_wren_a), 32'd1);
    check("rr_last_in_a", rf_in_a, 32'h205);
    idle();

    // Starvation: 4 writes then a forced read, repeating.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      int g;
      g = i % 5;
      @(negedge clk);
      wb0_valid = 1'b1; wb0_rd = 5'd3; wb0_data = 32'h33;
      wb1_valid = 1'b1; wb1_rd = 5'd4; wb1_data = 32'h44;
      rd_req_valid = 1'b1; rd_rs1 = 5'd3; rd_rs2 = 5'd4; rd_tag = 4'd7;
      #1;
      check("st_rd_ready", 32'(rd_req_ready), (g == 4) ? 32'd1 : 32'd0);
      check("st_wb0_ready", 32'(wb0_ready), (g < 4 && g % 2 == 0) ? 32'd1 : 32'd0);
      check("st_wb1_ready", 32'(wb1_ready), (g < 4 && g % 2 == 1) ? 32'd1 : 32'd0);
      if (rd_req_ready) begin
        exp_t e;
        e.rs1 = 32'h33; e.rs2 = 32'h44; e.tag = 4'd7; e.due = cyc + 3;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    idle();
    repeat (4) @(negedge clk);

    // Write to x0 is accepted but never enabled.
    @(negedge clk);
    wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 32'h1234;
    #1 check("x0_wb1_ready", 32'(wb1_ready), 32'd1);
    @(negedge clk);
    check("x0_wren", 32'(rf_wren_a), 32'd0);
    idle();
    read_cycle(5'd0, 5'd0, 4'd5, 32'd0, 32'd0);
    @(negedge clk);
    idle();
    repeat (4) @(negedge clk);

    // Three back-to-back reads.
    read_cycle(5'd1, 5'd2, 4'd1, 32'h104, 32'h205);
    read_cycle(5'd5, 5'd3, 4'd2, 32'hDEADBEEF, 32'h33);
    read_cycle(5'd4, 5'd0, 4'd3, 32'h44, 32'd0);
    @(negedge clk);
    idle();
    repeat (5) @(negedge clk);

    // Reset one cycle after a read handshake: response must be discarded.
    @(negedge clk);
    rd_req_valid = 1'b1; rd_rs1 = 5'd5; rd_rs2 = 5'd3; rd_tag = 4'd9;
    #1 check("mid_rd_ready", 32'(rd_req_ready), 32'd1);
    @(negedge clk);
    idle();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    check("mid_rsp_rs1", rd_rsp_rs1, 32'd0);
    check("mid_rsp_rs2", rd_rsp_rs2, 32'd0);
    check("mid_rsp_tag", 32'(rd_rsp_tag), 32'd0);
    check("mid_addr_a", 32'(rf_address_a), 32'd0);
    check("mid_addr_b", 32'(rf_address_b), 32'd0);
    check("mid_in_a", rf_in_a, 32'd0);
    check("mid_wren", 32'(rf_wren_a), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
